// File: rtl/despertador_timer_mc.sv
// despertador_timer_mc: multi-channel prescaled interval timer on a 16-bit Avalon-MM slave
// Ports: clk, reset_n (async active-low); address[4:3] channel, [2:0] register;
//        chipselect, write_n, writedata: slave write side; readdata: registered read data;
//        irq: OR of irq_vec; irq_vec: per-channel TO & ITO
module despertador_timer_mc #(
    parameter int          NUM_CHANNELS  = 2,
    parameter int          COUNTER_WIDTH = 32,
    parameter logic [31:0] RESET_PERIOD  = 32'h2FAF07F
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4:0]              address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [15:0]             writedata,
    output logic [15:0]             readdata,
    output logic                    irq,
    output logic [NUM_CHANNELS-1:0] irq_vec
);
    localparam int W = COUNTER_WIDTH;
    localparam logic [W-1:0] RST_PERIOD = W'(RESET_PERIOD);
    logic [W-1:0] r_cnt [NUM_CHANNELS];
    logic [W-1:0] r_period [NUM_CHANNELS];
    logic [W-1:0] r_snap [NUM_CHANNELS];
    logic [7:0] r_prescale [NUM_CHANNELS];
    logic [7:0] r_pcount [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] r_ito, r_cont, r_start, r_stop, r_run, r_to, r_reload;
    logic [NUM_CHANNELS-1:0] w_wsta, w_wctl, w_wper, w_wsnap, w_tick, w_exp;
    logic [W-1:0] w_per_nxt [NUM_CHANNELS];
    logic [31:0] w_ptmp, w_stmp, w_ntmp;
    logic [15:0] w_rd;
    logic w_wr, w_sel;
    logic [1:0] w_ch;
    logic [2:0] w_reg;
    assign w_wr = chipselect & ~write_n;
    assign w_ch = address[4:3];
    assign w_reg = address[2:0];
    assign irq_vec = r_to & r_ito;
    assign irq = |irq_vec;
    // Period/snapshot are widened to 32 bits so the high halfword works for any width;
    // the loop only covers existing channels, so absent channels read 0 and ignore writes.
    always_comb begin
        w_rd = '0;
        w_sel = 1'b0;
        w_ptmp = '0;
        w_stmp = '0;
        w_ntmp = '0;
        w_wsta = '0;
        w_wctl = '0;
        w_wper = '0;
        w_wsnap = '0;
        w_tick = '0;
        w_exp = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_sel = w_wr && w_ch == 2'(i);
            w_wsta[i] = w_sel && w_reg == 3'd0;
            w_wctl[i] = w_sel && w_reg == 3'd1;
            w_wper[i] = w_sel && w_reg[2:1] == 2'b01;
            w_wsnap[i] = w_sel && w_reg[2:1] == 2'b10;
            w_tick[i] = r_run[i] && r_pcount[i] == 8'd0;
            w_exp[i] = w_tick[i] && r_cnt[i] == '0;
            w_ptmp = 32'(r_period[i]);
            w_stmp = 32'(r_snap[i]);
            w_ntmp = w_reg[0] ? {writedata, w_ptmp[15:0]} : {w_ptmp[31:16], writedata};
            w_per_nxt[i] = w_ntmp[W-1:0];
            if (w_ch == 2'(i))
                w_rd = w_reg == 3'd0 ? {14'd0, r_run[i], r_to[i]} :
                       w_reg == 3'd1 ? {r_prescale[i], 4'd0, r_stop[i], r_start[i], r_cont[i], r_ito[i]} :
                       w_reg == 3'd2 ? w_ptmp[15:0] :
                       w_reg == 3'd3 ? w_ptmp[31:16] :
                       w_reg == 3'd4 ? w_stmp[15:0] :
                       w_reg == 3'd5 ? w_stmp[31:16] :
                       w_reg == 3'd7 ? 16'(irq_vec) : 16'd0;
        end
    end
    // RUN priority: period write > START > STOP > one-shot expiry.
    // TO set beats a STATUS clear; snapshot takes the pre-update counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            r_ito <= '0;
            r_cont <= '0;
            r_start <= '0;
            r_stop <= '0;
            r_run <= '0;
            r_to <= '0;
            r_reload <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_cnt[i] <= RST_PERIOD;
                r_period[i] <= RST_PERIOD;
                r_snap[i] <= '0;
                r_prescale[i] <= '0;
                r_pcount[i] <= '0;
            end
        end else begin
            readdata <= w_rd;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (w_wctl[i]) begin
                    r_ito[i] <= writedata[0];
                    r_cont[i] <= writedata[1];
                    r_start[i] <= writedata[2];
                    r_stop[i] <= writedata[3];
                    r_prescale[i] <= writedata[15:8];
                end
                if (w_wper[i])
                    r_period[i] <= w_per_nxt[i];
                if (w_wsnap[i])
                    r_snap[i] <= r_cnt[i];
                r_reload[i] <= w_wper[i];
                if (r_reload[i])
                    r_pcount[i] <= r_prescale[i];
                else if (r_run[i])
                    r_pcount[i] <= r_pcount[i] == 8'd0 ? r_prescale[i] : r_pcount[i] - 8'd1;
                if (r_reload[i])
                    r_cnt[i] <= r_period[i];
                else if (w_tick[i])
                    r_cnt[i] <= w_exp[i] ? r_period[i] : r_cnt[i] - W'(1);
                r_to[i] <= w_exp[i] | (r_to[i] & ~w_wsta[i]);
                r_run[i] <= w_wper[i] ? 1'b0 :
                            (w_wctl[i] && writedata[2]) ? 1'b1 :
                            (w_wctl[i] && writedata[3]) ? 1'b0 :
                            (w_exp[i] && !r_cont[i]) ? 1'b0 : r_run[i];
            end
        end
    end
endmodule

// File: tb/tb_despertador_timer_mc.sv
// tb_despertador_timer_mc: directed checks of the timer on a 2x32 and a 1x20 instance
module tb_despertador_timer_mc;
    logic clk = 1'b0;
    logic reset_n, reset_n2;
    logic [4:0] address;
    logic chipselect, write_n;
    logic [15:0] writedata;
    logic [15:0] rdata, rdata2;
    logic irq, irq2;
    logic [1:0] irq_vec;
    logic [0:0] irq_vec2;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    despertador_timer_mc dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rdata), .irq(irq), .irq_vec(irq_vec)
    );

    despertador_timer_mc #(.NUM_CHANNELS(1), .COUNTER_WIDTH(20)) dut2 (
        .clk(clk), .reset_n(reset_n2), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rdata2), .irq(irq2), .irq_vec(irq_vec2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered and left at a negedge; exactly one posedge carries the write.
    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic rd(input logic [4:0] a);
        address = a;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        reset_n2 = 1'b0;
        address = '0;
        chipselect = 1'b0;
        write_n = 1'b1;
        writedata = '0;
        repeat (2) @(negedge clk);
        chk("rst_rdata", rdata, 0);
        chk("rst_irq", irq, 0);
        chk("rst_irq_vec", irq_vec, 0);
        reset_n = 1'b1;
        @(negedge clk);
        rd(2);  chk("ch0_perl_rst", rdata, 16'hF07F);
        rd(3);  chk("ch0_perh_rst", rdata, 16'h02FA);
        rd(10); chk("ch1_perl_rst", rdata, 16'hF07F);
        rd(11); chk("ch1_perh_rst", rdata, 16'h02FA);
        rd(0);  chk("ch0_status_rst", rdata, 0);
        rd(8);  chk("ch1_status_rst", rdata, 0);
        chk("irq_idle", irq, 0);
        // ch0 one-shot, period 5, prescale 0
        wr(1, 16'h0001);
        wr(2, 16'd5);
        wr(3, 16'd0);
        wr(1, 16'h0005);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("os_early", irq_vec[0], 0);
        end
        @(negedge clk);
        chk("os_to", irq_vec[0], 1);
        chk("os_irq", irq, 1);
        rd(15); chk("irq_pend_ch1_slot", rdata, 16'h0001);
        rd(0);  chk("os_status", rdata, 16'h0001);
        wr(4, 16'd0);
        rd(4);  chk("os_cnt_reload", rdata, 16'd5);
        wr(0, 16'd0);
        chk("os_irq_clr", irq, 0);
        // ch1 continuous, period 3, prescale 2, ITO on
        wr(9, 16'h0203);
        wr(10, 16'd3);
        wr(11, 16'd0);
        wr(9, 16'h0207);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            chk("c1_early", irq_vec[1], 0);
        end
        @(negedge clk);
        chk("c1_to1", irq_vec[1], 1);
        chk("c1_ch0_idle", irq_vec[0], 0);
        wr(8, 16'd0);
        chk("c1_clr", irq_vec[1], 0);
        for (int k = 14; k <= 23; k++) begin
            @(negedge clk);
            chk("c1_gap", irq_vec[1], 0);
        end
        @(negedge clk);
        chk("c1_to2", irq_vec[1], 1);
        wr(12, 16'd0); rd(12); chk("c1_snap_a", rdata, 16'd3);
        wr(12, 16'd0); rd(12); chk("c1_snap_preupd", rdata, 16'd3);
        wr(12, 16'd0); rd(12); chk("c1_snap_b", rdata, 16'd2);
        wr(12, 16'd0); rd(12); chk("c1_snap_c", rdata, 16'd1);
        wr(8, 16'd0);
        rd(0); chk("ch0_still_idle", rdata, 0);
        @(negedge clk);
        wr(8, 16'd0);
        rd(8); chk("sta_clr_vs_to", rdata, 16'h0003);
        wr(8, 16'd0);
        wr(9, 16'h0008);
        // ch1 one-shot period 1000, prescale 0
        wr(10, 16'd1000);
        wr(9, 16'h0004);
        repeat (300) @(negedge clk);
        wr(12, 16'd0);
        rd(12); chk("snap_700_l", rdata, 16'd700);
        rd(13); chk("snap_700_h", rdata, 16'd0);
        wr(10, 16'd10);
        rd(8); chk("perw_run_clr", rdata, 16'd0);
        wr(12, 16'd0);
        rd(12); chk("perw_reload", rdata, 16'd10);
        wr(9, 16'h000C);
        rd(8); chk("start_stop_run", rdata, 16'h0002);
        rd(9); chk("ctrl_readback", rdata, 16'h000C);
        // 1 channel, 20-bit instance
        chk("d2_rst_rdata", rdata2, 0);
        chk("d2_rst_irq", irq2, 0);
        reset_n2 = 1'b1;
        @(negedge clk);
        rd(2); chk("d2_perl_rst", rdata2, 16'hF07F);
        rd(3); chk("d2_perh_rst", rdata2, 16'h000A);
        wr(18, 16'h1234);
        rd(18); chk("d2_ch2_read0", rdata2, 0);
        rd(2);  chk("d2_ch2_wr_ignored", rdata2, 16'hF07F);
        rd(31); chk("d2_ch3_pend0", rdata2, 0);
        wr(3, 16'hFFFF);
        rd(3); chk("d2_perh_trunc", rdata2, 16'h000F);
        wr(2, 16'd2);
        wr(3, 16'd0);
        wr(1, 16'h0007);
        repeat (5) @(negedge clk);
        address = 5'd2;
        @(negedge clk);
        chk("d2_pre_rdata", rdata2, 16'd2);
        chk("d2_pre_irq", irq2, 1);
        #2 reset_n2 = 1'b0;
        #1;
        chk("d2_async_rdata", rdata2, 0);
        chk("d2_async_irq", irq2, 0);
        chk("d2_async_irqvec", irq_vec2, 0);
        @(negedge clk);
        reset_n2 = 1'b1;
        repeat (3) @(negedge clk);
        rd(0); chk("d2_idle_status", rdata2, 0);
        chk("d2_idle_irq", irq2, 0);
        rd(2); chk("d2_perl_after_rst", rdata2, 16'hF07F);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/despertador_timer_mc.md
# despertador_timer_mc

Multi-channel, parametrised Avalon-MM interval timer for the DespertadorCPU system, replacing the single fixed 32-bit timer. It provides `NUM_CHANNELS` independent down-counters, each with a configurable width, an 8-bit prescaler, one-shot/continuous mode, snapshot capture and a maskable timeout interrupt. The block sits on the Nios II data master as a 16-bit slave and drives one combined IRQ line plus a per-channel pending vector.

## Interface
- `NUM_CHANNELS`, 2: number of timer channels, 1..4.
- `COUNTER_WIDTH`, 32: counter and period width, 16..32.
- `RESET_PERIOD`, 32'h2FAF07F: reset value of every period register and counter; truncated to `COUNTER_WIDTH`.
- `clk`  in  1: single clock domain.
- `reset_n`  in  1: asynchronous, active-low reset.
- `address`  in  5: [4:3] channel select, [2:0] register select.
- `chipselect`  in  1: slave select.
- `write_n`  in  1: active-low write strobe.
- `writedata`  in  16: write data.
- `readdata`  out  16: registered read data.
- `irq`  out  1: OR of `irq_vec`.
- `irq_vec`  out  NUM_CHANNELS: per-channel TO & ITO.

## Operation
- Register map per channel:
  - 0 STATUS: read {RUN, TO} in bits [1:0]; any write clears TO.
  - 1 CONTROL: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP, bits[15:8] PRESCALE.
    - Bits 0, 1 and [15:8] are stored; bits 2 and 3 act as strobes and read back as last written.
  - 2 PERIOD_L, 3 PERIOD_H: period bits [15:0] and [COUNTER_WIDTH-1:16].
    - Unused high bits are ignored on write and read as 0.
  - 4 SNAP_L, 5 SNAP_H: any write to either captures the channel counter; reads return the snapshot.
  - 6: reserved, reads 0.
  - 7 IRQ_PEND: read {0, irq_vec}, identical from every channel slot; writes ignored.
- Addresses to channels ≥ `NUM_CHANNELS` read 0; writes to them are ignored.
- Prescaler (per channel):
  - `pcount` counts down from PRESCALE while RUN=1.
  - A tick is emitted when `pcount`==0, and `pcount` is then reloaded with PRESCALE.
  - PRESCALE=0 gives a tick every clock.
- Counter (on each tick while RUN=1):
  - If counter==0: reload PERIOD, set TO, and clear RUN if CONT=0.
  - Otherwise: decrement by 1.
  - A one-shot therefore lasts (PERIOD+1)×(PRESCALE+1) clocks from the START write.
- START sets RUN without reloading the counter. STOP clears RUN and freezes the counter and `pcount`.
- A write to PERIOD_L or PERIOD_H:
  - clears RUN in the same cycle;
  - on the next cycle, reloads the counter from the new PERIOD and `pcount` from PRESCALE.
- Simultaneous events, required priority:
  - START and STOP in the same write: START wins.
  - START in the same cycle as a one-shot expiry: RUN=1.
  - STATUS write in the same cycle as a timeout: TO=1 (the event is not lost).
  - SNAP write in the same cycle as a counter update: captures the pre-update value.
- Reset values:
  - counter = PERIOD = RESET_PERIOD.
  - CONTROL, RUN, TO, `pcount`, snapshot = 0.
  - `readdata` = 0, `irq` = 0, `irq_vec` = 0.

## Timing
- `readdata` is registered every clock from `address`, independent of `chipselect`. Read latency is 1 cycle.
- Write side effects occur at the `clk` edge where `chipselect` & ~`write_n`. Readback reflects them 2 edges later.
- TO sets on the tick edge where counter==0. `irq_vec` and `irq` are combinational from TO and ITO, so they assert in the same cycle TO is set.
- `reset_n` assertion mid-count aborts immediately and asynchronously. After deassertion, nothing runs until a START write.

## Test plan
- Reset, then read each channel (offsets 2 and 3):
  - PERIOD_L=0xF07F, PERIOD_H=0x02FA.
  - STATUS=0, `irq`=0.
- Ch0 setup:
  - PERIOD_L=5, PERIOD_H=0, PRESCALE=0, CONT=0, ITO=1, then START.
  - Required: TO and `irq_vec[0]` assert exactly 6 clocks after the START edge; RUN=0 afterwards; counter=5.
  - Write STATUS: `irq` drops on the next cycle.
- Ch1 setup:
  - PERIOD=3, PRESCALE=2, CONT=1, START.
  - Required: a timeout every 12 clocks; counter sequence 3,2,1,0,3, each value held 3 clocks.
  - Ch0 remains idle throughout.
- Ch1 running with period 1000:
  - Write SNAP_L when counter=700. Required: SNAP_L reads 700 and SNAP_H reads 0.
  - Write PERIOD_L=10. Required: RUN=0 and counter=10 one cycle later.
- Same-cycle collisions:
  - STATUS write coinciding with a timeout: TO stays 1.
  - CONTROL write with START|STOP (0x000C): RUN=1.
- `NUM_CHANNELS`=1, `COUNTER_WIDTH`=20:
  - Write channel-2 PERIOD_L: ignored; channel-2 addresses read 0.
  - Write PERIOD_H=0xFFFF: reads back 0x000F.
  - Assert `reset_n` mid-count: all outputs return to reset values immediately.
